// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART vector-record framer.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_SYNCED = 2'd1,
    ST_RECORD = 2'd2
  } frame_state_t;

  localparam int REC_WIDTH = 32;
  localparam int REC_BYTES = 4;
  localparam int IDX_WIDTH = 2;

  localparam logic [7:0] DEFAULT_END_BYTE = 8'h01;

  function automatic logic [REC_WIDTH-1:0] end_record(input logic [7:0] end_byte);
    return {REC_BYTES{end_byte}};
  endfunction

  localparam logic [REC_WIDTH-1:0] END_RECORD = {REC_BYTES{DEFAULT_END_BYTE}};

endpackage

// File: rtl/uart_frame_ctrl_gap_timer.sv
// Inter-byte gap timer: down-counter reloaded on every strobe, one-cycle expiry
// when TIMEOUT_CLKS consecutive enabled clocks pass without a strobe.
module uart_gap_timer #(
  parameter int TIMEOUT_CLKS = 2048
) (
  input  logic i_Clock,
  input  logic i_Reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT_CLKS - 1);

  logic [CNT_W-1:0] count;

  // A strobe in the terminal cycle suppresses expiry.
  assign expire = enable && !clear && (count == '0);

  always_ff @(posedge i_Clock) begin
    if (i_Reset || clear || !enable || expire) begin
      count <= LOAD_VAL;
    end else begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frames the uart_rx byte stream into 32-bit vector records: hunts for a zero
// preamble, assembles 4-byte records, detects end records and gap timeouts.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_HUNT   | counting consecutive 8'h00 bytes toward a sync preamble
//   ST_SYNCED | preamble seen; absorbing extra zeros until first data byte
//   ST_RECORD | assembling 4-byte records; 8'h00 is ordinary data
module uart_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         SYNC_LEN     = 8,
  parameter logic [7:0] END_BYTE     = 8'h01,
  parameter int         TIMEOUT_CLKS = 2048
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Rec_Valid,
  input  logic        i_Rec_Ready,
  output logic [31:0] o_Rec_Data,
  output logic        o_Frame_Start,
  output logic        o_Frame_End,
  output logic        o_Overflow,
  output logic        o_Timeout
);

  localparam int ZC_W = $clog2(SYNC_LEN + 1);
  localparam logic [ZC_W-1:0] SYNC_CNT = ZC_W'(SYNC_LEN);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(REC_BYTES - 1);
  localparam logic [REC_WIDTH-1:0] END_WORD = end_record(END_BYTE);

  frame_state_t         state_q, state_d;
  logic [ZC_W-1:0]      zero_cnt_q, zero_cnt_d;
  logic [IDX_WIDTH-1:0] byte_idx_q, byte_idx_d;
  logic [23:0]          shift_q, shift_d;
  logic                 rec_valid_q, rec_valid_d;
  logic [31:0]          rec_data_q, rec_data_d;
  logic                 start_q, start_d;
  logic                 end_q, end_d;
  logic                 ovf_q, ovf_d;
  logic                 tmo_q, tmo_d;

  logic                 gap_enable;
  logic                 gap_expire;
  logic [31:0]          word;
  logic                 emit;

  // In HUNT the timer only matters while a partial preamble is pending.
  assign gap_enable = (state_q != ST_HUNT) || (zero_cnt_q != '0);
  assign word       = {shift_q, i_Rx_Byte};

  uart_gap_timer #(
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_gap_timer (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .clear  (i_Rx_DV),
    .enable (gap_enable),
    .expire (gap_expire)
  );

  always_comb begin
    state_d     = state_q;
    zero_cnt_d  = zero_cnt_q;
    byte_idx_d  = byte_idx_q;
    shift_d     = shift_q;
    rec_valid_d = rec_valid_q && !i_Rec_Ready;
    rec_data_d  = rec_data_q;
    start_d     = 1'b0;
    end_d       = 1'b0;
    ovf_d       = 1'b0;
    tmo_d       = 1'b0;
    emit        = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == 8'h00) begin
            if (zero_cnt_q != SYNC_CNT) begin
              zero_cnt_d = zero_cnt_q + 1'b1;
            end
            if (zero_cnt_q + 1'b1 == SYNC_CNT) begin
              state_d = ST_SYNCED;
              start_d = 1'b1;
            end
          end else begin
            zero_cnt_d = '0;
          end
        end else if (gap_expire) begin
          zero_cnt_d = '0;
        end
      end

      ST_SYNCED: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte != 8'h00) begin
            shift_d    = {16'h0, i_Rx_Byte};
            byte_idx_d = IDX_WIDTH'(1);
            state_d    = ST_RECORD;
          end
        end else if (gap_expire) begin
          tmo_d      = 1'b1;
          state_d    = ST_HUNT;
          zero_cnt_d = '0;
          byte_idx_d = '0;
          shift_d    = '0;
        end
      end

      ST_RECORD: begin
        if (i_Rx_DV) begin
          shift_d = word[23:0];
          if (byte_idx_q == LAST_IDX) begin
            byte_idx_d = '0;
            if (word == END_WORD) begin
              end_d      = 1'b1;
              state_d    = ST_HUNT;
              zero_cnt_d = '0;
            end else begin
              emit = 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end else if (gap_expire) begin
          tmo_d      = 1'b1;
          state_d    = ST_HUNT;
          zero_cnt_d = '0;
          byte_idx_d = '0;
          shift_d    = '0;
        end
      end

      default: begin
        state_d    = ST_HUNT;
        zero_cnt_d = '0;
        byte_idx_d = '0;
      end
    endcase

    // The output slot is free if empty or being drained this same cycle.
    if (emit) begin
      if (!rec_valid_q || i_Rec_Ready) begin
        rec_valid_d = 1'b1;
        rec_data_d  = word;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q     <= ST_HUNT;
      zero_cnt_q  <= '0;
      byte_idx_q  <= '0;
      shift_q     <= '0;
      rec_valid_q <= 1'b0;
      rec_data_q  <= '0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      ovf_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_cnt_q  <= zero_cnt_d;
      byte_idx_q  <= byte_idx_d;
      shift_q     <= shift_d;
      rec_valid_q <= rec_valid_d;
      rec_data_q  <= rec_data_d;
      start_q     <= start_d;
      end_q       <= end_d;
      ovf_q       <= ovf_d;
      tmo_q       <= tmo_d;
    end
  end

  assign o_Rec_Valid   = rec_valid_q;
  assign o_Rec_Data    = rec_data_q;
  assign o_Frame_Start = start_q;
  assign o_Frame_End   = end_q;
  assign o_Overflow    = ovf_q;
  assign o_Timeout     = tmo_q;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: directed byte streams push expected
// events; a negedge monitor pops and compares every event the DUT presents.
module tb_uart_frame_ctrl;

  localparam int T = 32;

  localparam int EV_START = 0;
  localparam int EV_REC   = 1;
  localparam int EV_END   = 2;
  localparam int EV_OVF   = 3;
  localparam int EV_TMO   = 4;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Rx_DV = 1'b0;
  logic [7:0]  i_Rx_Byte = 8'h00;
  logic        i_Rec_Ready = 1'b0;
  logic        o_Rec_Valid;
  logic [31:0] o_Rec_Data;
  logic        o_Frame_Start;
  logic        o_Frame_End;
  logic        o_Overflow;
  logic        o_Timeout;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } evt_t;

  evt_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  uart_frame_ctrl #(
    .SYNC_LEN    (8),
    .END_BYTE    (8'h01),
    .TIMEOUT_CLKS(T)
  ) dut (
    .i_Clock      (i_Clock),
    .i_Reset      (i_Reset),
    .i_Rx_DV      (i_Rx_DV),
    .i_Rx_Byte    (i_Rx_Byte),
    .o_Rec_Valid  (o_Rec_Valid),
    .i_Rec_Ready  (i_Rec_Ready),
    .o_Rec_Data   (o_Rec_Data),
    .o_Frame_Start(o_Frame_Start),
    .o_Frame_End  (o_Frame_End),
    .o_Overflow   (o_Overflow),
    .o_Timeout    (o_Timeout)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic expect_evt(input int k, input logic [31:0] d);
    evt_t e;
    e.kind = k;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_evt(input int k, input logic [31:0] d);
    evt_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%h, required no event", k, d);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != k || (k == EV_REC && e.data != d)) begin
        errors++;
        $display("FAIL event_order: got kind=%0d data=%h, required kind=%0d data=%h",
                 k, d, e.kind, e.data);
      end
    end
  endtask

  always @(negedge i_Clock) begin
    if (!i_Reset) begin
      if (o_Frame_Start)              check_evt(EV_START, 32'h0);
      if (o_Rec_Valid && i_Rec_Ready) check_evt(EV_REC, o_Rec_Data);
      if (o_Frame_End)                check_evt(EV_END, 32'h0);
      if (o_Overflow)                 check_evt(EV_OVF, 32'h0);
      if (o_Timeout)                  check_evt(EV_TMO, 32'h0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Drives one strobe, then 'gap' idle clocks; returns #1 after the last edge.
  task automatic send(input logic [7:0] b, input int gap);
    i_Rx_DV   = 1'b1;
    i_Rx_Byte = b;
    @(posedge i_Clock); #1;
    i_Rx_DV   = 1'b0;
    i_Rx_Byte = 8'hxx;
    repeat (gap) begin
      @(posedge i_Clock); #1;
    end
  endtask

  task automatic send4(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send(w[31-8*i -: 8], 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_Clock); #1;
    end
  endtask

  task automatic sync8();
    expect_evt(EV_START, 32'h0);
    for (int i = 0; i < 8; i++) send(8'h00, 0);
  endtask

  task automatic drain_and_reset(input string name);
    idle(6);
    chk(name, exp_q.size(), 0);
    i_Reset = 1'b1;
    idle(1);
    i_Reset = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    idle(2);
    i_Reset = 1'b0;
    chk("reset_outputs",
        {27'h0, o_Rec_Valid, o_Frame_Start, o_Frame_End, o_Overflow, o_Timeout}, 32'h0);
    chk("reset_data", o_Rec_Data, 32'h0);

    // Basic frame with consumer always ready.
    i_Rec_Ready = 1'b1;
    sync8();
    chk("start_pulse", o_Frame_Start, 1);
    expect_evt(EV_REC, 32'h01020304);
    send4(32'h01020304);
    chk("rec_latency", o_Rec_Valid, 1);
    chk("rec_latency_data", o_Rec_Data, 32'h01020304);
    expect_evt(EV_REC, 32'h02040608);
    send4(32'h02040608);
    expect_evt(EV_END, 32'h0);
    send4(32'h01010101);
    drain_and_reset("t1_drained");

    // Consumer stalled: first record held, later ones overflow.
    i_Rec_Ready = 1'b0;
    sync8();
    send4(32'h010A0A0A);
    expect_evt(EV_OVF, 32'h0);
    send4(32'h02141414);
    expect_evt(EV_OVF, 32'h0);
    send4(32'h031E1E1E);
    expect_evt(EV_END, 32'h0);
    send4(32'h01010101);
    idle(2);
    chk("held_valid", o_Rec_Valid, 1);
    chk("held_data", o_Rec_Data, 32'h010A0A0A);
    expect_evt(EV_REC, 32'h010A0A0A);
    i_Rec_Ready = 1'b1;
    idle(1);
    chk("valid_drop", o_Rec_Valid, 0);
    drain_and_reset("t2_drained");

    // Broken preamble must restart the zero count.
    for (int i = 0; i < 7; i++) send(8'h00, 0);
    send(8'h05, 0);
    sync8();
    drain_and_reset("t3_drained");

    // Gap of exactly T clocks aborts; trailing bytes are ignored.
    sync8();
    send(8'h01, 0);
    expect_evt(EV_TMO, 32'h0);
    send(8'h02, T);
    chk("timeout_pulse", o_Timeout, 1);
    send4(32'h03040506);
    drain_and_reset("t4_drained");

    // Strobe landing in the expiry cycle wins.
    sync8();
    expect_evt(EV_REC, 32'h01020304);
    send(8'h01, T - 1);
    send(8'h02, T - 1);
    send(8'h03, 0);
    send(8'h04, 0);
    drain_and_reset("t5_drained");

    // Gapped preamble in HUNT: T idle clocks clear it, T-1 does not.
    for (int i = 0; i < 3; i++) send(8'h00, 0);
    send(8'h00, T);
    for (int i = 0; i < 4; i++) send(8'h00, 0);
    send(8'h05, 0);
    idle(4);
    chk("gapped_no_sync", exp_q.size(), 0);
    expect_evt(EV_START, 32'h0);
    for (int i = 0; i < 3; i++) send(8'h00, 0);
    send(8'h00, T - 1);
    for (int i = 0; i < 4; i++) send(8'h00, 0);
    expect_evt(EV_END, 32'h0);
    send4(32'h01010101);
    drain_and_reset("t6_drained");

    // Extra zeros after sync are absorbed; zeros inside a record are data.
    sync8();
    send(8'h00, 0);
    send(8'h00, 0);
    expect_evt(EV_REC, 32'h07000009);
    send4(32'h07000009);
    drain_and_reset("t7_drained");

    // Reset mid-record discards the held record and partial bytes.
    i_Rec_Ready = 1'b0;
    sync8();
    send4(32'h11223344);
    chk("pre_reset_valid", o_Rec_Valid, 1);
    chk("pre_reset_data", o_Rec_Data, 32'h11223344);
    send(8'h55, 0);
    send(8'h66, 0);
    idle(2);
    chk("pre_reset_drained", exp_q.size(), 0);
    i_Reset = 1'b1;
    idle(1);
    i_Reset = 1'b0;
    chk("midreset_outputs",
        {27'h0, o_Rec_Valid, o_Frame_Start, o_Frame_End, o_Overflow, o_Timeout}, 32'h0);
    chk("midreset_data", o_Rec_Data, 32'h0);
    i_Rec_Ready = 1'b1;
    sync8();
    expect_evt(EV_REC, 32'hAABBCCDD);
    send4(32'hAABBCCDD);
    expect_evt(EV_END, 32'h0);
    send4(32'h01010101);
    idle(6);
    chk("t8_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
